// File: rtl/formal_chk_pkg.sv
// Shared definitions for the formal output checker: FSM state encoding,
// default parameter values and the "no error seen" sentinel index.
package formal_chk_pkg;

   localparam int unsigned DEF_WIDTH       = 1;
   localparam int unsigned DEF_SKIP_CYCLES = 1;
   localparam int unsigned DEF_RUN_CYCLES  = 4;
   localparam int unsigned DEF_CNT_W       = 16;

   // Width of the compare-cycle index and first-error capture
   localparam int unsigned IDX_W = 16;
   localparam logic [IDX_W-1:0] NO_ERR_IDX = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SKIP  = 3'd1,
      ST_CHECK = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/chk_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, reset (sync, active-high), clr_i (sync clear), inc_i (count
// enable), count_o (current value, sticks at all-ones).
module chk_sat_counter
   import formal_chk_pkg::*;
#(
   parameter int unsigned W = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Clear wins over increment; increment stops at the maximum value
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/formal_output_checker.sv
// Compares an FPGA fabric output vector against a reference benchmark vector
// over a fixed window, counting mismatch events and recording the first one.
// Ports: clk, reset (sync, active-high), start (run pulse), gfpga_out,
// bench_out, bench_dc (don't-care mask); busy, done, pass, mismatch_flag,
// mismatch_vec, nb_error (saturating event count), first_err_cycle.
module formal_output_checker
   import formal_chk_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned SKIP_CYCLES = DEF_SKIP_CYCLES,
   parameter int unsigned RUN_CYCLES  = DEF_RUN_CYCLES,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] gfpga_out,
   input  logic [WIDTH-1:0] bench_out,
   input  logic [WIDTH-1:0] bench_dc,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch_flag,
   output logic [WIDTH-1:0] mismatch_vec,
   output logic [CNT_W-1:0] nb_error,
   output logic [IDX_W-1:0] first_err_cycle
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             start_run;

   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             mm_flag_q, mm_flag_d;
   logic             flag_prev_q, flag_prev_d;
   logic [WIDTH-1:0] mm_vec_q, mm_vec_d;
   logic [IDX_W-1:0] mm_idx_q, mm_idx_d;
   logic [IDX_W-1:0] first_err_q, first_err_d;
   logic             event_c;
   logic [CNT_W-1:0] nb_error_c;

   // Next-state logic; cnt_q times each phase and is the compare index in CHECK
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      start_run = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_SKIP;
               cnt_d     = '0;
               start_run = 1'b1;
            end
         end
         ST_SKIP: begin
            if (cnt_q == IDX_W'(SKIP_CYCLES - 1)) begin
               state_d = ST_CHECK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         ST_CHECK: begin
            if (cnt_q == IDX_W'(RUN_CYCLES - 1)) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         ST_DRAIN: begin
            if (cnt_q == IDX_W'(1)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // An event is the rising edge of the registered mismatch flag
   assign event_c = mm_flag_q & ~flag_prev_q;

   // Datapath next values
   always_comb begin
      mm_vec_d    = '0;
      mm_idx_d    = mm_idx_q;
      first_err_d = first_err_q;

      if (state_q == ST_CHECK) begin
         mm_vec_d = (gfpga_out ^ bench_out) & ~bench_dc;
         mm_idx_d = cnt_q;
      end
      mm_flag_d   = |mm_vec_d;
      flag_prev_d = start_run ? 1'b0 : mm_flag_q;

      if (start_run) begin
         first_err_d = NO_ERR_IDX;
      end else if (event_c && (first_err_q == NO_ERR_IDX)) begin
         first_err_d = mm_idx_q;
      end

      done_d = (state_d == ST_DONE);
      busy_d = (state_d == ST_SKIP) || (state_d == ST_CHECK) || (state_d == ST_DRAIN);
      pass_d = done_d && (nb_error_c == '0) && !event_c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         mm_flag_q   <= 1'b0;
         flag_prev_q <= 1'b0;
         mm_vec_q    <= '0;
         mm_idx_q    <= '0;
         first_err_q <= NO_ERR_IDX;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         mm_flag_q   <= mm_flag_d;
         flag_prev_q <= flag_prev_d;
         mm_vec_q    <= mm_vec_d;
         mm_idx_q    <= mm_idx_d;
         first_err_q <= first_err_d;
      end
   end

   chk_sat_counter #(
      .W (CNT_W)
   ) u_err_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (start_run),
      .inc_i   (event_c),
      .count_o (nb_error_c)
   );

   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign mismatch_flag   = mm_flag_q;
   assign mismatch_vec    = mm_vec_q;
   assign nb_error        = nb_error_c;
   assign first_err_cycle = first_err_q;

endmodule

// File: doc/formal_output_checker.md
FORMAL_OUTPUT_CHECKER -- requirements
Module: formal_output_checker

Interface
REQ-001 Parameter WIDTH, default 1, is the number of compared output bits.
REQ-002 Parameter SKIP_CYCLES, default 1, is the number of initialization cycles skipped before comparing (1..255).
REQ-003 Parameter RUN_CYCLES, default 4, is the number of compare cycles per run (1..65535).
REQ-004 Parameter CNT_W, default 16, is the width of the error counter.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse that begins a run.
REQ-008 gfpga_out  input  WIDTH  FPGA fabric output vector under test.
REQ-009 bench_out  input  WIDTH  reference benchmark output vector.
REQ-010 bench_dc  input  WIDTH  per-bit don't-care mask; a 1 excludes that bit from comparison (stands in for unknown benchmark values).
REQ-011 busy  output  1  high from the cycle after an accepted start until done rises.
REQ-012 done  output  1  run complete; held until the next accepted start or reset.
REQ-013 pass  output  1  equals done AND nb_error==0.
REQ-014 mismatch_flag  output  1  registered per-cycle mismatch indication.
REQ-015 mismatch_vec  output  WIDTH  registered (gfpga_out XOR bench_out) AND NOT bench_dc.
REQ-016 nb_error  output  CNT_W  count of mismatch events, saturating.
REQ-017 first_err_cycle  output  16  compare-cycle index (0-based) of the first mismatch; 0xFFFF if none.

Function
REQ-018 FSM states: IDLE, SKIP, CHECK, DRAIN, DONE.
REQ-019 IDLE->SKIP on start; start in any state other than IDLE or DONE is ignored.
REQ-020 DONE->SKIP on start; nb_error, first_err_cycle, done and mismatch_flag clear in that transition.
REQ-021 SKIP lasts exactly SKIP_CYCLES cycles; no comparison occurs in SKIP.
REQ-022 CHECK lasts exactly RUN_CYCLES cycles; each cycle samples the inputs.
REQ-023 DRAIN lasts exactly 2 cycles, then the FSM enters DONE and done rises.
REQ-024 In CHECK, mismatch_vec and mismatch_flag (OR of mismatch_vec) update one cycle after sampling; outside CHECK they load 0.
REQ-025 A mismatch event is a 0->1 transition of mismatch_flag; consecutive mismatching cycles count as one event.
REQ-026 nb_error increments the cycle after the event and saturates at 2^CNT_W-1 without wrapping.
REQ-027 first_err_cycle captures the compare index only on the first event of a run.
REQ-028 Fully masked bits (bench_dc=1) never cause a mismatch regardless of gfpga_out.
REQ-029 Total latency start->done = 1 + SKIP_CYCLES + RUN_CYCLES + 2 cycles.

Reset
REQ-030 reset forces IDLE and clears busy, done, pass, mismatch_flag, mismatch_vec, nb_error to 0 and first_err_cycle to 0xFFFF.
REQ-031 reset mid-run aborts without asserting done; reset has priority over simultaneous start.

Structure
REQ-032 Package formal_chk_pkg holds the FSM state enum and the default parameter constants.
REQ-033 A single sub-module chk_sat_counter (parameterized width, increment enable, clear, saturation) implements nb_error.

Verification (WIDTH=4, SKIP_CYCLES=1, RUN_CYCLES=8)
REQ-034 Identical vectors on every cycle, one start -> done at cycle 12 after start, nb_error=0, pass=1, first_err_cycle=0xFFFF.
REQ-035 gfpga_out=4'h1 vs bench_out=4'h0 at compare indices 2 and 5 only -> nb_error=2, first_err_cycle=2, pass=0.
REQ-036 Mismatch held on compare indices 3..6 -> nb_error=1; mismatch_flag high for 4 cycles.
REQ-037 Differing bit 3 with bench_dc=4'h8 throughout -> nb_error=0, pass=1.
REQ-038 CNT_W=2 with alternating mismatch every other compare cycle -> nb_error saturates at 3.
REQ-039 reset asserted during CHECK -> next cycle IDLE, all outputs at reset values, no done pulse; a start during busy has no effect.
